// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode encodings (also
// used by the alu), instruction phase numbers, and a small opcode classifier.
package risc_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_HLT = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_STO = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'b111;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  // Instructions that read a memory operand and write the accumulator.
  function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> datapath bundle.
//   master (controller): takes opcode/zero, drives strobes, halt and phase.
//   slave  (datapath)  : drives opcode/zero, takes the rest.
interface risc_controller_if;
  import risc_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                sel;
  logic                rd;
  logic                ld_ir;
  logic                inc_pc;
  logic                ld_pc;
  logic                ld_ac;
  logic                data_e;
  logic                wr;
  logic                halt;
  logic [2:0]          phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase
  );
endinterface

// File: rtl/risc_controller_ctrl_decode.sv
// ctrl_decode: purely combinational strobe decoder.
// Ports: phase/opcode/zero/halted in; sel, rd, ld_ir, inc_pc, ld_pc, ld_ac,
// data_e, wr, halt out. Opcode only matters in phases 4-7, zero only in 6.
module ctrl_decode
  import risc_pkg::*;
(
  input  logic [2:0]          phase,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                halted,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                data_e,
  output logic                wr,
  output logic                halt
);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      // Frozen: only halt is asserted, every datapath strobe held low.
      halt = 1'b1;
    end else begin
      unique case (phase)
        PH_INST_ADDR: sel = 1'b1;
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          // The halt-entry cycle still bumps the PC past the HLT.
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: rd = is_aluop(opcode);
        PH_ALU_OP: begin
          rd     = is_aluop(opcode);
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = is_aluop(opcode);
          ld_ac  = is_aluop(opcode);
          inc_pc = (opcode == OP_JMP);
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/risc_controller.sv
// risc_controller: 8-phase instruction sequencer (fetch 0-3, execute 4-7).
// Ports: clk, rst_n (async low), bus (risc_controller_if.master), and
// resume when CTRL_RESUME_EN is defined.
// CTRL_RESUME_EN: adds a resume input that leaves the halted state; the HLT
// then completes as a NOP from phase 5. Without it only rst_n leaves halt.
// Holds only the phase counter and the halted flag; strobes come from
// ctrl_decode.
module risc_controller
  import risc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
`ifdef CTRL_RESUME_EN
  input  logic               resume,
`endif
  risc_controller_if.master  bus
);

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;

  always_comb begin
    phase_d  = phase_q + 3'd1;
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
`ifdef CTRL_RESUME_EN
      if (resume) begin
        halted_d = 1'b0;
        phase_d  = PH_OP_FETCH;
      end
`endif
    end else if (phase_q == PH_OP_ADDR && bus.opcode == OP_HLT) begin
      // Park at phase 4 so a resume can finish the HLT as a NOP.
      halted_d = 1'b1;
      phase_d  = phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  assign bus.phase = phase_q;

  ctrl_decode u_decode (
    .phase  (phase_q),
    .opcode (bus.opcode),
    .zero   (bus.zero),
    .halted (halted_q),
    .sel    (bus.sel),
    .rd     (bus.rd),
    .ld_ir  (bus.ld_ir),
    .inc_pc (bus.inc_pc),
    .ld_pc  (bus.ld_pc),
    .ld_ac  (bus.ld_ac),
    .data_e (bus.data_e),
    .wr     (bus.wr),
    .halt   (bus.halt)
  );

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: a table of instructions with expected
// execute-phase strobes, plus hand sequences for halt and async reset.
// Strobe word order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt}.
module tb_risc_controller;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef CTRL_RESUME_EN
  logic resume = 1'b0;
`endif

  risc_controller_if bus ();

  risc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef CTRL_RESUME_EN
    .resume(resume),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct packed {
    logic [2:0]       op;
    logic             z;
    logic [0:3][8:0]  ex;   // expected strobes for phases 4..7
  } vec_t;

  vec_t vecs [8];
  logic [0:3][8:0] fetch_ex;

  function automatic logic [8:0] strobes();
    return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
            bus.ld_ac, bus.data_e, bus.wr, bus.halt};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Runs one full instruction from phase 0; assumes we sit just after a
  // negedge at phase 0. Opcode/zero are scrambled during fetch to show they
  // are ignored there.
  task automatic run_instr(input vec_t v, input int idx);
    for (int p = 0; p < 8; p++) begin
      bus.opcode = (p < 4) ? ~v.op : v.op;
      bus.zero   = (p < 4) ? ~v.z  : v.z;
      #1;
      chk($sformatf("v%0d phase%0d", idx, p), {6'd0, bus.phase}, 9'(p));
      chk($sformatf("v%0d strobes%0d", idx, p), strobes(),
          (p < 4) ? fetch_ex[p] : v.ex[p-4]);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    fetch_ex = {9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000};
    //               op      z     ph4           ph5           ph6           ph7
    vecs[0] = '{OP_ADD, 1'b0, {9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000}};
    vecs[1] = '{OP_AND, 1'b1, {9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000}};
    vecs[2] = '{OP_XOR, 1'b0, {9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000}};
    vecs[3] = '{OP_LDA, 1'b1, {9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000}};
    vecs[4] = '{OP_SKZ, 1'b1, {9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000}};
    vecs[5] = '{OP_SKZ, 1'b0, {9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000}};
    vecs[6] = '{OP_STO, 1'b1, {9'b000100000, 9'b000000000, 9'b000000100, 9'b000000110}};
    vecs[7] = '{OP_JMP, 1'b0, {9'b000100000, 9'b000000000, 9'b000010000, 9'b000110000}};

    bus.opcode = OP_ADD;
    bus.zero   = 1'b0;
    @(negedge clk);
    do_reset();
    #1;
    chk("reset phase", {6'd0, bus.phase}, 9'd0);
    chk("reset strobes", strobes(), 9'b100000000);
    @(negedge clk);
    // that negedge advanced phase to 1; realign to phase 0
    do_reset();

    foreach (vecs[i]) run_instr(vecs[i], i);

    // HLT: entry cycle pulses inc_pc with halt, then frozen at phase 4.
    for (int p = 0; p < 4; p++) @(negedge clk);
    bus.opcode = OP_HLT;
    #1;
    chk("hlt entry phase", {6'd0, bus.phase}, 9'd4);
    chk("hlt entry strobes", strobes(), 9'b000100001);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.opcode = OP_JMP;
      bus.zero   = c[0];
      #1;
      chk($sformatf("halted phase c%0d", c), {6'd0, bus.phase}, 9'd4);
      chk($sformatf("halted strobes c%0d", c), strobes(), 9'b000000001);
    end
    rst_n = 1'b0;
    #1;
    chk("halt rst phase", {6'd0, bus.phase}, 9'd0);
    chk("halt rst strobes", strobes(), 9'b100000000);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CTRL_RESUME_EN
    for (int p = 0; p < 4; p++) @(negedge clk);
    bus.opcode = OP_HLT;
    repeat (3) @(negedge clk);
    resume = 1'b1;
    #1;
    chk("pre-resume halt", strobes(), 9'b000000001);
    @(negedge clk);
    resume = 1'b0;
    #1;
    chk("resume phase", {6'd0, bus.phase}, 9'd5);
    chk("resume strobes", strobes(), 9'b000000000);
    repeat (3) @(negedge clk);
    #1;
    chk("post-resume phase", {6'd0, bus.phase}, 9'd0);
    chk("post-resume strobes", strobes(), 9'b100000000);
    // realign to phase 0 after the negedge boundary
    @(negedge clk);
    do_reset();
    // resume outside halt does nothing
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #1;
    chk("resume ignored", {6'd0, bus.phase}, 9'd1);
    do_reset();
`endif

    // Async reset in phase 7 of STO drops wr before any clock edge.
    for (int p = 0; p < 7; p++) @(negedge clk);
    bus.opcode = OP_STO;
    #1;
    chk("sto ph7 wr", strobes(), 9'b000000110);
    rst_n = 1'b0;
    #1;
    chk("async rst strobes", strobes(), 9'b100000000);
    chk("async rst phase", {6'd0, bus.phase}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
